mb_rtu_frame_parser: RTL

- Downstream consumer of the Modbus RTU receive stage.
- Waits for the end-of-frame timeout pulse, then drains the receive FIFO (normal-mode scfifo: q valid the cycle after rdreq).
- Runs a bit-serial CRC-16/MODBUS check, checks slave address and function code, and presents the decoded request (0x03 read holding / 0x06 write single) to the register-map stage.
- Clears the FIFO after every frame, whether accepted or rejected.

---
 rtl/mb_rtu_frame_parser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mb_rtu_frame_parser.sv
// Modbus RTU request parser: drains one frame from the receive FIFO, checks CRC-16/MODBUS,
// address and function code, and presents 0x03/0x06 requests. Optional: `MB_BROADCAST_EN.
module mb_rtu_frame_parser #(
   parameter int unsigned CNT_W     = 10,
   parameter int unsigned FRAME_LEN = 8,
   parameter logic [15:0] CRC_POLY  = 16'hA001,
   parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_done,
   input  logic [CNT_W-1:0] fifo_cnt,
   input  logic [7:0]       fifo_q,
   input  logic [7:0]       slave_addr,
   output logic             fifo_rd,
   output logic             fifo_clr,
   output logic             busy,
   output logic             frame_valid,
   output logic             bcast,
   output logic [7:0]       func_code,
   output logic [15:0]      start_addr,
   output logic [15:0]      word_val,
   output logic             crc_err,
   output logic             len_err,
   output logic             func_err
);

   localparam int unsigned IDX_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned HDR_LEN = 6;
   localparam int unsigned HDR_W   = 8 * HDR_LEN;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_RD, S_CAP, S_SHIFT, S_DONE, S_CLR
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      crc_q, crc_d, crc_shift;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [2:0]       bit_q, bit_d;
   logic [HDR_W-1:0] hdr_q, hdr_d;
   logic             last_bit, last_byte, finish;
   logic             addr_ok, func_ok;

   logic             fifo_rd_d, fifo_clr_d, busy_d;
   logic             frame_valid_d, crc_err_d, len_err_d, func_err_d;
   logic [7:0]       func_code_d;
   logic [15:0]      start_addr_d, word_val_d;

   assign last_bit  = (bit_q == 3'd7);
   assign last_byte = (idx_q == IDX_W'(FRAME_LEN - 1));
   assign finish    = (state_q == S_SHIFT) && last_bit && last_byte;
   assign crc_shift = crc_q[0] ? ((crc_q >> 1) ^ CRC_POLY) : (crc_q >> 1);
   assign func_ok   = (hdr_q[39:32] == 8'h03) || (hdr_q[39:32] == 8'h06);

`ifdef MB_BROADCAST_EN
   logic bcast_d;
   assign addr_ok = (hdr_q[47:40] == slave_addr) || (hdr_q[47:40] == 8'h00);
`else
   assign addr_ok = (hdr_q[47:40] == slave_addr);
   assign bcast   = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; the length verdict is the registered len_err pulse seen in CHECK
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (frame_done) state_d = S_CHECK;
         S_CHECK: state_d = len_err ? S_CLR : S_RD;
         S_RD:    state_d = S_CAP;
         S_CAP:   state_d = S_SHIFT;
         S_SHIFT: if (last_bit) state_d = last_byte ? S_DONE : S_RD;
         S_DONE:  state_d = S_CLR;
         S_CLR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: CRC, byte index, bit counter, header shift register (bytes 0..5)
   always_comb begin
      crc_d = crc_q;
      idx_d = idx_q;
      bit_d = bit_q;
      hdr_d = hdr_q;
      case (state_q)
         S_CHECK: begin
            crc_d = CRC_INIT;
            idx_d = '0;
         end
         S_CAP: begin
            crc_d = crc_q ^ {8'h00, fifo_q};
            bit_d = 3'd0;
            if (32'(idx_q) < HDR_LEN) hdr_d = {hdr_q[HDR_W-9:0], fifo_q};
         end
         S_SHIFT: begin
            crc_d = crc_shift;
            bit_d = bit_q + 3'd1;
            if (last_bit && !last_byte) idx_d = idx_q + IDX_W'(1);
         end
         default: ;
      endcase
   end

   // Output logic: values for the registered outputs; verdict taken on the final CRC shift
   always_comb begin
      fifo_rd_d     = (state_d == S_RD);
      fifo_clr_d    = (state_d == S_CLR);
      busy_d        = (state_d != S_IDLE);
      len_err_d     = (state_q == S_IDLE) && frame_done && (fifo_cnt != CNT_W'(FRAME_LEN));
      frame_valid_d = 1'b0;
      crc_err_d     = 1'b0;
      func_err_d    = 1'b0;
      func_code_d   = func_code;
      start_addr_d  = start_addr;
      word_val_d    = word_val;
`ifdef MB_BROADCAST_EN
      bcast_d       = bcast;
`endif
      if (finish) begin
         if (crc_d != 16'h0000) begin
            crc_err_d = 1'b1;
         end else if (!addr_ok) begin
            frame_valid_d = 1'b0;
         end else if (!func_ok) begin
            func_err_d = 1'b1;
         end else begin
            frame_valid_d = 1'b1;
            func_code_d   = hdr_q[39:32];
            start_addr_d  = hdr_q[31:16];
            word_val_d    = hdr_q[15:0];
`ifdef MB_BROADCAST_EN
            bcast_d       = (hdr_q[47:40] == 8'h00);
`endif
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q       <= '0;
         idx_q       <= '0;
         bit_q       <= '0;
         hdr_q       <= '0;
         fifo_rd     <= 1'b0;
         fifo_clr    <= 1'b0;
         busy        <= 1'b0;
         frame_valid <= 1'b0;
         crc_err     <= 1'b0;
         len_err     <= 1'b0;
         func_err    <= 1'b0;
         func_code   <= '0;
         start_addr  <= '0;
         word_val    <= '0;
`ifdef MB_BROADCAST_EN
         bcast       <= 1'b0;
`endif
      end else begin
         crc_q       <= crc_d;
         idx_q       <= idx_d;
         bit_q       <= bit_d;
         hdr_q       <= hdr_d;
         fifo_rd     <= fifo_rd_d;
         fifo_clr    <= fifo_clr_d;
         busy        <= busy_d;
         frame_valid <= frame_valid_d;
         crc_err     <= crc_err_d;
         len_err     <= len_err_d;
         func_err    <= func_err_d;
         func_code   <= func_code_d;
         start_addr  <= start_addr_d;
         word_val    <= word_val_d;
`ifdef MB_BROADCAST_EN
         bcast       <= bcast_d;
`endif
      end
   end

endmodule
